// File: rtl/esp32_osd_renderer.sv
// esp32_osd_renderer: overlays a 256x128 text OSD (32x16 cells of 8x8 glyphs) onto a video stream with 3-cycle latency
module esp32_osd_renderer #(
   parameter int          OSD_X  = 192,
   parameter int          OSD_Y  = 176,
   parameter logic [23:0] FG_RGB = 24'hFFFFFF,
   parameter bit          DIM_BG = 1'b1
) (
   input  logic        clk_video,
   input  logic        rst_n,
   input  logic        osd_enable,
   input  logic [9:0]  vid_x,
   input  logic [9:0]  vid_y,
   input  logic        vid_de,
   input  logic        vid_hs,
   input  logic        vid_vs,
   input  logic [23:0] vid_rgb,
   output logic [11:0] buf_rd_addr,
   input  logic [7:0]  buf_rd_data,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        out_de,
   output logic        out_hs,
   output logic        out_vs,
   output logic [23:0] out_rgb,
   output logic        osd_active
);
   logic        en_s1, en_s2, en_frame, vs_d;
   logic        in_win, in_win1, in_win2;
   logic [7:0]  rel_x;
   logic [6:0]  rel_y;
   logic [2:0]  rx1, rx2, ry1;
   logic [26:0] v1, v2;
   logic        pix_on;
   logic [23:0] half;

   assign in_win = vid_de && en_frame &&
                   ({1'b0, vid_x} >= 11'(OSD_X)) && ({1'b0, vid_x} < 11'(OSD_X + 256)) &&
                   ({1'b0, vid_y} >= 11'(OSD_Y)) && ({1'b0, vid_y} < 11'(OSD_Y + 128));
   assign rel_x  = vid_x[7:0] - 8'(OSD_X);
   assign rel_y  = vid_y[6:0] - 7'(OSD_Y);
   assign pix_on = font_data[3'd7 - rx2];
   assign half   = {1'b0, v2[23:17], 1'b0, v2[15:9], 1'b0, v2[7:1]};

   // Synchronise the enable request and only adopt it at the start of a frame
   always_ff @(posedge clk_video or negedge rst_n) begin
      if (!rst_n) begin
         {en_s1, en_s2, en_frame, vs_d} <= '0;
      end else begin
         en_s1 <= osd_enable;
         en_s2 <= en_s1;
         vs_d  <= vid_vs;
         if (vid_vs && !vs_d) en_frame <= en_s2;
      end
   end

   // Text-buffer lookup, then glyph-row lookup, with video and window flag carried alongside
   always_ff @(posedge clk_video or negedge rst_n) begin
      if (!rst_n) begin
         buf_rd_addr <= '0;
         font_addr   <= '0;
         {in_win1, in_win2, rx1, rx2, ry1, v1, v2} <= '0;
      end else begin
         if (in_win) buf_rd_addr <= {3'b000, rel_y[6:3], rel_x[7:3]};
         in_win1   <= in_win;
         rx1       <= rel_x[2:0];
         ry1       <= rel_y[2:0];
         v1        <= {vid_de, vid_hs, vid_vs, vid_rgb};
         font_addr <= {buf_rd_data, ry1};
         in_win2   <= in_win1;
         rx2       <= rx1;
         v2        <= v1;
      end
   end

   // Composite: glyph colour on set bits, optionally dimmed video on clear bits inside the window
   always_ff @(posedge clk_video or negedge rst_n) begin
      if (!rst_n) begin
         {out_de, out_hs, out_vs, osd_active, out_rgb} <= '0;
      end else begin
         {out_de, out_hs, out_vs} <= v2[26:24];
         osd_active <= in_win2;
         out_rgb    <= !in_win2 ? v2[23:0] : pix_on ? FG_RGB : DIM_BG ? half : v2[23:0];
      end
   end
endmodule

// File: tb/tb_esp32_osd_renderer.sv
// tb_esp32_osd_renderer: randomized self-checking bench against a cell/glyph arithmetic model of the OSD
module tb_esp32_osd_renderer;
   localparam int          OSD_X  = 192;
   localparam int          OSD_Y  = 176;
   localparam logic [23:0] FG_RGB = 24'hFFFFFF;

   logic        clk_video = 1'b0;
   logic        rst_n = 1'b0;
   logic        osd_enable = 1'b0;
   logic [9:0]  vid_x = '0, vid_y = '0;
   logic        vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
   logic [23:0] vid_rgb = '0;
   logic [11:0] buf_rd_addr;
   logic [7:0]  buf_rd_data;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic        out_de, out_hs, out_vs, osd_active;
   logic [23:0] out_rgb;

   logic [7:0]  buf_mem [4096];
   logic [7:0]  font_mem [2048];
   logic [27:0] exp_q[$], obs_q[$];
   logic [11:0] ba_q[$];
   logic [10:0] fa_q[$];
   bit          en_m, last_vs;
   int          n_cmp = 0, n_err = 0;

   assign buf_rd_data = buf_mem[buf_rd_addr];
   assign font_data   = font_mem[font_addr];

   esp32_osd_renderer #(.OSD_X(OSD_X), .OSD_Y(OSD_Y), .FG_RGB(FG_RGB), .DIM_BG(1'b1)) dut (
      .clk_video(clk_video), .rst_n(rst_n), .osd_enable(osd_enable),
      .vid_x(vid_x), .vid_y(vid_y), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
      .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .font_addr(font_addr), .font_data(font_data),
      .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb), .osd_active(osd_active)
   );

   initial forever #5 clk_video = ~clk_video;

   function automatic logic [27:0] model(input int x, input int y, input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
      bit          w;
      int          rx, ry;
      logic [7:0]  ch, row;
      logic [23:0] o;
      w  = de && en_m && x >= OSD_X && x < OSD_X + 256 && y >= OSD_Y && y < OSD_Y + 128;
      rx = x - OSD_X;
      ry = y - OSD_Y;
      o  = rgb;
      if (w) begin
         ch  = buf_mem[(ry / 8) * 32 + rx / 8];
         row = font_mem[int'(ch) * 8 + ry % 8];
         o   = row[7 - rx % 8] ? FG_RGB : {rgb[23:16] / 8'd2, rgb[15:8] / 8'd2, rgb[7:0] / 8'd2};
      end
      return {de, hs, vs, w, o};
   endfunction

   task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
      @(negedge clk_video);
      vid_x = 10'(x); vid_y = 10'(y); vid_de = de; vid_hs = hs; vid_vs = vs; vid_rgb = rgb;
      exp_q.push_back(model(x, y, de, hs, vs, rgb));
      if (vs && !last_vs) en_m = osd_enable;
      last_vs = vs;
      @(posedge clk_video);
      #1;
      obs_q.push_back({out_de, out_hs, out_vs, osd_active, out_rgb});
      ba_q.push_back(buf_rd_addr);
      fa_q.push_back(font_addr);
   endtask

   task automatic clear_q();
      exp_q.delete(); obs_q.delete(); ba_q.delete(); fa_q.delete();
   endtask

   task automatic vsync_frame(input bit en);
      osd_enable = en;
      repeat (3) drive(0, 0, 0, 0, 0, 24'h0);
      repeat (2) drive(0, 0, 0, 0, 1, 24'h0);
      drive(0, 0, 0, 0, 0, 24'h0);
   endtask

   task automatic test_reset();
      #23;
      n_cmp++;
      if ({out_de, out_hs, out_vs, osd_active, out_rgb, buf_rd_addr, font_addr} !== 51'h0) begin
         n_err++;
         $display("FAIL reset outputs got %h want 0", {out_de, out_hs, out_vs, osd_active, out_rgb, buf_rd_addr, font_addr});
      end
      @(negedge clk_video);
      rst_n = 1'b1;
      en_m = 1'b0;
      last_vs = 1'b0;
   endtask

   task automatic test_passthrough();
      logic [23:0] r;
      vsync_frame(0);
      clear_q();
      for (int k = 0; k < 40; k++) drive(180 + k * 3, 170 + k, 1, k % 5 == 0, 0, 24'(k) * 24'h010203);
      repeat (2) drive(0, 0, 0, 0, 0, 24'h0);
      for (int k = 0; k < 40; k++) begin
         r = 24'(k) * 24'h010203;
         n_cmp++;
         if (obs_q[k + 2] !== exp_q[k] || obs_q[k + 2][23:0] !== r || obs_q[k + 2][24] !== 1'b0) begin
            n_err++;
            $display("FAIL passthrough px%0d got %h want %h", k, obs_q[k + 2], exp_q[k]);
         end
      end
   endtask

   task automatic test_glyph();
      logic [23:0] rgbs [8];
      logic [23:0] want;
      buf_mem[0] = 8'h41;
      font_mem[11'h208] = 8'h18;
      vsync_frame(1);
      clear_q();
      for (int k = 0; k < 8; k++) begin
         rgbs[k] = 24'($urandom);
         drive(OSD_X + k, OSD_Y, 1, 0, 0, rgbs[k]);
      end
      repeat (2) drive(0, 0, 0, 0, 0, 24'h0);
      n_cmp++;
      if (ba_q[0] !== 12'h000) begin
         n_err++;
         $display("FAIL glyph buf_rd_addr got %h want 000", ba_q[0]);
      end
      for (int k = 0; k < 8; k++) begin
         want = (k == 3 || k == 4) ? FG_RGB : (rgbs[k] >> 1) & 24'h7F7F7F;
         n_cmp++;
         if (fa_q[k + 1] !== 11'h208) begin
            n_err++;
            $display("FAIL glyph font_addr px%0d got %h want 208", k, fa_q[k + 1]);
         end
         n_cmp++;
         if (obs_q[k + 2][23:0] !== want || obs_q[k + 2][24] !== 1'b1 || obs_q[k + 2] !== exp_q[k]) begin
            n_err++;
            $display("FAIL glyph px%0d got %h want rgb %h", k, obs_q[k + 2], want);
         end
      end
   endtask

   task automatic test_bounds();
      clear_q();
      drive(447, 303, 1, 0, 0, 24'h123456);
      drive(448, 303, 1, 0, 0, 24'h654321);
      drive(447, 304, 1, 0, 0, 24'hABCDEF);
      repeat (2) drive(0, 0, 0, 0, 0, 24'h0);
      n_cmp++;
      if (ba_q[0] !== 12'd511) begin
         n_err++;
         $display("FAIL bounds buf_rd_addr got %0d want 511", ba_q[0]);
      end
      n_cmp++;
      if ({obs_q[2][24], obs_q[3][24], obs_q[4][24]} !== 3'b100) begin
         n_err++;
         $display("FAIL bounds osd_active got %b want 100", {obs_q[2][24], obs_q[3][24], obs_q[4][24]});
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (obs_q[k + 2] !== exp_q[k]) begin
            n_err++;
            $display("FAIL bounds px%0d got %h want %h", k, obs_q[k + 2], exp_q[k]);
         end
      end
   endtask

   task automatic test_blanking();
      clear_q();
      for (int k = 0; k < 20; k++) drive($urandom_range(OSD_X, OSD_X + 255), $urandom_range(OSD_Y, OSD_Y + 127), 0, 1, 0, 24'($urandom));
      repeat (2) drive(0, 0, 0, 0, 0, 24'h0);
      for (int k = 0; k < 20; k++) begin
         n_cmp++;
         if (obs_q[k + 2] !== exp_q[k]) begin
            n_err++;
            $display("FAIL blanking px%0d got %h want %h", k, obs_q[k + 2], exp_q[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 512; i++) buf_mem[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
      vsync_frame(1);
      clear_q();
      for (int k = 0; k < 300; k++)
         drive($urandom_range(180, 460), $urandom_range(170, 310), $urandom_range(0, 3) != 0, 1'($urandom), 0, 24'($urandom));
      repeat (2) drive(0, 0, 0, 0, 0, 24'h0);
      for (int k = 0; k < 300; k++) begin
         n_cmp++;
         if (obs_q[k + 2] !== exp_q[k]) begin
            n_err++;
            $display("FAIL random px%0d got %h want %h", k, obs_q[k + 2], exp_q[k]);
         end
      end
   endtask

   task automatic test_enable_timing();
      vsync_frame(0);
      clear_q();
      for (int k = 0; k < 48; k++) begin
         if (k == 10) osd_enable = 1'b1;
         drive(OSD_X + k, 200, 1, 0, 0, 24'($urandom));
      end
      vsync_frame(1);
      for (int k = 0; k < 48; k++) begin
         if (k == 10) osd_enable = 1'b0;
         drive(OSD_X + k, 200, 1, 0, 0, 24'($urandom));
      end
      vsync_frame(0);
      for (int k = 0; k < 16; k++) drive(OSD_X + k, 200, 1, 0, 0, 24'($urandom));
      repeat (2) drive(0, 0, 0, 0, 0, 24'h0);
      for (int k = 0; k < exp_q.size() - 2; k++) begin
         n_cmp++;
         if (obs_q[k + 2] !== exp_q[k]) begin
            n_err++;
            $display("FAIL enable_timing px%0d got %h want %h", k, obs_q[k + 2], exp_q[k]);
         end
      end
      n_cmp++;
      if (exp_q[60][24] !== 1'b1 || obs_q[62][24] !== 1'b1) begin
         n_err++;
         $display("FAIL enable_timing active_after_vsync got %b want 1", obs_q[62][24]);
      end
   endtask

   task automatic test_async_reset();
      vsync_frame(1);
      for (int k = 0; k < 5; k++) drive(OSD_X + 8 + k, OSD_Y + 4, 1, 1, 0, 24'($urandom));
      @(posedge clk_video);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_de, out_hs, out_vs, osd_active, out_rgb, buf_rd_addr, font_addr} !== 51'h0) begin
         n_err++;
         $display("FAIL async_reset outputs got %h want 0", {out_de, out_hs, out_vs, osd_active, out_rgb, buf_rd_addr, font_addr});
      end
      en_m = 1'b0;
      last_vs = 1'b0;
      @(negedge clk_video);
      rst_n = 1'b1;
      clear_q();
      for (int k = 0; k < 6; k++) drive(OSD_X + 16 + k, OSD_Y + 9, 1, 0, 0, 24'($urandom));
      vsync_frame(1);
      for (int k = 0; k < 6; k++) drive(OSD_X + 16 + k, OSD_Y + 9, 1, 0, 0, 24'($urandom));
      repeat (2) drive(0, 0, 0, 0, 0, 24'h0);
      for (int k = 0; k < exp_q.size() - 2; k++) begin
         n_cmp++;
         if (obs_q[k + 2] !== exp_q[k]) begin
            n_err++;
            $display("FAIL async_reset px%0d got %h want %h", k, obs_q[k + 2], exp_q[k]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) buf_mem[i] = 8'h00;
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
      test_reset();
      test_passthrough();
      test_glyph();
      test_bounds();
      test_blanking();
      test_random();
      test_enable_timing();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
